mul_seq: RTL and testbench

// - Upstream operand sequencer for the synchronous multiplier (mul_intf slave).
// - Buffers incoming operand pairs in a small FIFO and issues them to the multiplier one at a time.
// - Drives en, a and b; waits for ack; captures out.
// - Presents each product on a valid/ready result port, giving the multiplier a flow-controlled front end.

---
 rtl/mul_seq_pkg.sv | 13 +
 rtl/mul_seq_fifo.sv | 42 ++++
 rtl/mul_seq.sv | 152 +++++++++++++++
 tb/tb_mul_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and constants for the mul_seq operand sequencer
package mul_seq_pkg;

  localparam int MUL_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} mul_seq_state_t;

  typedef struct packed {
    logic [MUL_DATA_W-1:0] a;
    logic [MUL_DATA_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/mul_seq_fifo.sv
// rtl/mul_seq_fifo.sv - operand pair FIFO with extra-MSB pointers for full/empty detection
module mul_seq_fifo
  import mul_seq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = operand_pair_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, rd_q;
  T            mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers mark them valid.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - FIFO-buffered operand sequencer feeding a synchronous multiplier
// Optional WAIT timeout enabled by defining MUL_SEQ_TIMEOUT_EN.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int DATA_W  = MUL_DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic                mul_en,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic [2*DATA_W-1:0] mul_out,
  input  logic                mul_ack,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*DATA_W-1:0] res_data,
  output logic                busy,
  output logic                err
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;

  mul_seq_state_t      state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                vld_q, vld_d;
  logic                full, empty, pop;
  pair_t               fifo_in, fifo_out;

  assign fifo_in = '{a: in_a, b: in_b};

  mul_seq_fifo #(.DEPTH(DEPTH), .T(pair_t)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (in_valid),
    .data_i (fifo_in),
    .pop_i  (pop),
    .data_o (fifo_out),
    .full_o (full),
    .empty_o(empty)
  );

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    vld_d   = vld_q;
    pop     = 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          a_d     = fifo_out.a;
          b_d     = fifo_out.b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MUL_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (mul_ack) begin
          res_d   = mul_out;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
`ifdef MUL_SEQ_TIMEOUT_EN
        // Abort drops the operation; the product is never presented.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (res_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
`ifdef MUL_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef MUL_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = !full;
  assign mul_en    = (state_q == ISSUE);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign res_valid = vld_q;
  assign res_data  = res_q;
  assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq with a registered multiplier model
module tb_mul_seq;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b;
  logic        mul_en, mul_ack;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_out;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        busy, err;
  logic        ack_kill = 1'b0;
  logic        spur = 1'b0;

  int          n_pass = 0;
  int          n_total = 0;
  int          en_cnt = 0;
  logic [15:0] exp_q [$];

  mul_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out), .mul_ack(mul_ack),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Multiplier: samples en, answers with ack and the product one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_ack <= 1'b0;
      mul_out <= '0;
    end else begin
      mul_ack <= (mul_en && !ack_kill) || spur;
      mul_out <= 16'(mul_a) * 16'(mul_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Advance one clock; any result handshake happening on this edge is scored.
  task automatic tick();
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) check("extra_result", 32'(exp_q.size()), 32'd1);
      else check("result", 32'(res_data), 32'(exp_q.pop_front()));
    end
    if (mul_en) en_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    if (in_ready) exp_q.push_back(16'(a) * 16'(b));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int e0;
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mul_en", 32'(mul_en), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_err", 32'(err), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // Single op: latency and single enable pulse
    res_ready = 1'b1;
    e0 = en_cnt;
    push(8'd10, 8'd2);
    tick();
    check("t1_issue_en", 32'(mul_en), 1);
    check("t1_mul_a", 32'(mul_a), 10);
    check("t1_mul_b", 32'(mul_b), 2);
    tick();
    check("t1_wait_en", 32'(mul_en), 0);
    check("t1_no_valid_yet", 32'(res_valid), 0);
    tick();
    check("t1_valid_at_3", 32'(res_valid), 1);
    check("t1_data", 32'(res_data), 20);
    tick();
    check("t1_valid_clear", 32'(res_valid), 0);
    check("t1_en_pulses", 32'(en_cnt - e0), 1);

    // Stray ack while idle must not produce a result
    spur = 1'b1;
    repeat (3) tick();
    spur = 1'b0;
    repeat (2) tick();
    check("spur_no_valid", 32'(res_valid), 0);
    check("spur_idle", 32'(busy), 0);

    // Burst with backpressure until full, then in-order drain
    res_ready = 1'b0;
    push(8'd9, 8'd9);
    push(8'd15, 8'd3);
    push(8'd255, 8'd255);
    push(8'd0, 8'd7);
    push(8'd1, 8'd1);
    check("burst_full", 32'(in_ready), 0);
    push(8'd2, 8'd2);
    push(8'd2, 8'd2);
    check("burst_still_full", 32'(in_ready), 0);
    res_ready = 1'b1;
    drain(60);
    tick();
    check("burst_idle", 32'(busy), 0);
    check("burst_ready", 32'(in_ready), 1);

    // Backpressure: result held stable, no new issue
    res_ready = 1'b0;
    push(8'd10, 8'd2);
    push(8'd7, 8'd6);
    for (int i = 0; i < 10 && !res_valid; i++) tick();
    check("bp_valid", 32'(res_valid), 1);
    e0 = en_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 32'(res_valid), 1);
      check("bp_hold_data", 32'(res_data), 20);
    end
    check("bp_no_en", 32'(en_cnt - e0), 0);
    res_ready = 1'b1;
    drain(30);
    tick();

    // Push on the pop edge at DEPTH-1 occupancy keeps the count
    res_ready = 1'b0;
    push(8'd3, 8'd5);
    push(8'd4, 8'd4);
    push(8'd6, 8'd7);
    push(8'd8, 8'd9);
    check("pp_hold", 32'(res_valid), 1);
    res_ready = 1'b1;
    tick();
    push(8'd11, 8'd13);
    check("pp_not_full", 32'(in_ready), 1);
    push(8'd12, 8'd12);
    check("pp_full_after", 32'(in_ready), 0);
    drain(60);
    tick();

    // Reset while in WAIT with two entries queued
    push(8'd10, 8'd2);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_en", 32'(mul_en), 0);
    check("mid_rst_a", 32'(mul_a), 0);
    check("mid_rst_valid", 32'(res_valid), 0);
    check("mid_rst_data", 32'(res_data), 0);
    check("mid_rst_ready", 32'(in_ready), 1);
    check("mid_rst_busy", 32'(busy), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    e0 = en_cnt;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid) seen++;
      tick();
    end
    check("mid_no_result", 32'(seen), 0);
    check("mid_no_issue", 32'(en_cnt - e0), 0);
    check("mid_idle", 32'(busy), 0);

`ifdef MUL_SEQ_TIMEOUT_EN
    begin
      int err_at;
      int err_n;
      ack_kill = 1'b1;
      err_at = -1;
      err_n = 0;
      seen = 0;
      push(8'd5, 8'd4);
      exp_q.delete();
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (err) begin
          err_n++;
          if (err_at < 0) err_at = k;
        end
        if (res_valid) seen++;
      end
      check("to_err_cycle", 32'(err_at), 32'(2 + TO));
      check("to_err_once", 32'(err_n), 1);
      check("to_no_valid", 32'(seen), 0);
      check("to_idle", 32'(busy), 0);
      ack_kill = 1'b0;
    end
`endif

    // Randomized traffic against the product queue
    for (int i = 0; i < 300; i++) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      in_valid = 1'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) exp_q.push_back(16'(in_a) * 16'(in_b));
      tick();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    drain(200);
    tick();
    check("rand_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
